// File: rtl/morse_seq.sv
// Morse symbol sequencer: snapshots five recorded pulse durations, classifies
// them into a dot/dash code one entry per cycle, hands the symbol downstream, then clears the recorder.
module morse_seq #(
  parameter int WID       = 32,
  parameter int DOT_MAX   = 10,
  parameter int MIN_PULSE = 1,
  parameter int CLR_CYC   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             rec_end,
  input  logic [5*WID-1:0] rec_value,
  output logic             rec_clr,
  output logic [4:0]       sym_code,
  output logic [2:0]       sym_len,
  output logic             sym_err,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             busy,
  output logic [7:0]       sym_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, OUT, CLEAR} state_t;

  typedef struct packed {
    logic [4:0] code;
    logic [2:0] len;
    logic       err;
  } sym_t;

  state_t               state_q, state_d;
  logic                 rec_end_q;
  logic [4:0][WID-1:0]  shad_q, shad_d;
  logic [2:0]           idx_q, idx_d;
  sym_t                 work_q, work_d, out_q, out_d;
  logic                 zero_q, zero_d;
  logic                 valid_q, valid_d;
  logic                 clr_q, clr_d;
  logic                 busy_q, busy_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           clr_cnt_q, clr_cnt_d;

  logic [WID-1:0]       entry;
  sym_t                 step;
  logic                 step_zero;

  // One SCAN step. A short pulse also terminates the symbol so that code
  // bits can never land at or above the pulse count.
  always_comb begin
    entry     = shad_q[idx_q];
    step      = work_q;
    step_zero = zero_q;
    if (entry == '0) begin
      step_zero = 1'b1;
    end else if (zero_q || (entry < WID'(MIN_PULSE))) begin
      step.err  = 1'b1;
      step_zero = 1'b1;
    end else begin
      step.code[idx_q] = (entry > WID'(DOT_MAX));
      step.len         = work_q.len + 3'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    shad_d    = shad_q;
    idx_d     = idx_q;
    work_d    = work_q;
    out_d     = out_q;
    zero_d    = zero_q;
    valid_d   = valid_q;
    clr_d     = clr_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (enable && rec_end && !rec_end_q) begin
          shad_d  = rec_value;
          work_d  = '0;
          zero_d  = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        work_d = step;
        zero_d = step_zero;
        idx_d  = idx_q + 3'd1;
        if (idx_q == 3'd4) begin
          out_d = step;
          if (step.len == 3'd0) out_d.err = 1'b1;
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (sym_ready) begin
          cnt_d     = cnt_q + 8'd1;
          valid_d   = 1'b0;
          clr_d     = 1'b1;
          clr_cnt_d = '0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == 8'(CLR_CYC - 1)) begin
          clr_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rec_end_q resets high so a recording held across reset release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rec_end_q <= 1'b1;
      shad_q    <= '0;
      idx_q     <= '0;
      work_q    <= '0;
      out_q     <= '0;
      zero_q    <= 1'b0;
      valid_q   <= 1'b0;
      clr_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rec_end_q <= rec_end;
      shad_q    <= shad_d;
      idx_q     <= idx_d;
      work_q    <= work_d;
      out_q     <= out_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
      clr_q     <= clr_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign rec_clr   = clr_q;
  assign sym_code  = out_q.code;
  assign sym_len   = out_q.len;
  assign sym_err   = out_q.err;
  assign sym_valid = valid_q;
  assign busy      = busy_q;
  assign sym_cnt   = cnt_q;

endmodule
